// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode channels of the fetch queue.
interface fetch_queue_if #(
    parameter int XLEN     = 32,
    parameter int FQ_DEPTH = 4
);
    logic                      redirect_valid;
    logic [XLEN-1:0]           redirect_pc;
    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [XLEN-1:0]           imem_req_addr;
    logic                      imem_rsp_valid;
    logic [XLEN-1:0]           imem_rsp_instr;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_instr;
    logic [XLEN-1:0]           out_pc;
    logic [$clog2(FQ_DEPTH):0] fq_count;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fq_count
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fq_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: credit-limited sequential fetch into an in-order instruction queue with redirect flush.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_pc [FQ_DEPTH];
    logic [XLEN-1:0] q_instr [FQ_DEPTH];
    logic [XLEN-1:0] pend_pc [FQ_DEPTH];
    logic [AW-1:0]   q_head, q_tail, p_head, p_tail, nxt_head;
    logic [CW-1:0]   count, inflight, drop_cnt, nxt_count;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            credit, issue, push, pop, drop;
    assign credit = ({1'b0, count} + {1'b0, inflight} + {1'b0, drop_cnt}) < (CW + 1)'(FQ_DEPTH);
    assign bus.imem_req_valid = reset && !bus.redirect_valid && credit;
    assign bus.out_valid      = reset && !bus.redirect_valid && count != '0;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.fq_count       = count;
    assign issue = bus.imem_req_valid && bus.imem_req_ready;
    assign pop   = bus.out_valid && bus.out_ready;
    assign drop  = bus.imem_rsp_valid && drop_cnt != '0;
    assign push  = bus.imem_rsp_valid && drop_cnt == '0 && inflight != '0 && !bus.redirect_valid;
    // Registered head view: a push into an emptying queue lands directly at the new head.
    always_comb begin
        nxt_head   = q_head + AW'(pop);
        nxt_count  = count + CW'(push) - CW'(pop);
        head_pc    = nxt_count == '0 ? '0 : (push && count == CW'(pop)) ? pend_pc[p_head] : q_pc[nxt_head];
        head_instr = nxt_count == '0 ? '0 : (push && count == CW'(pop)) ? bus.imem_rsp_instr : q_instr[nxt_head];
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc      <= RESET_PC;
            q_head        <= '0;
            q_tail        <= '0;
            p_head        <= '0;
            p_tail        <= '0;
            count         <= '0;
            inflight      <= '0;
            drop_cnt      <= '0;
            bus.out_pc    <= '0;
            bus.out_instr <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc      <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            q_head        <= '0;
            q_tail        <= '0;
            p_head        <= '0;
            p_tail        <= '0;
            count         <= '0;
            inflight      <= '0;
            drop_cnt      <= drop_cnt + inflight - CW'(bus.imem_rsp_valid && (drop_cnt != '0 || inflight != '0));
            bus.out_pc    <= '0;
            bus.out_instr <= '0;
        end else begin
            if (issue) begin
                pend_pc[p_tail] <= fetch_pc;
                p_tail          <= p_tail + AW'(1);
                fetch_pc        <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                q_pc[q_tail]    <= pend_pc[p_head];
                q_instr[q_tail] <= bus.imem_rsp_instr;
                q_tail          <= q_tail + AW'(1);
                p_head          <= p_head + AW'(1);
            end
            if (drop)
                drop_cnt <= drop_cnt - CW'(1);
            inflight      <= inflight + CW'(issue) - CW'(push);
            count         <= nxt_count;
            q_head        <= nxt_head;
            bus.out_pc    <= head_pc;
            bus.out_instr <= head_instr;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: random fetch traffic checked against a queue-based reference model.
module tb_fetch_queue_unit;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;
    fetch_queue_if #(.XLEN(32), .FQ_DEPTH(D)) bus ();
    fetch_queue_unit #(.XLEN(32), .RESET_PC(RPC), .FQ_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {int due; logic [31:0] instr;} mem_t;
    ent_t        fq[$];
    logic [31:0] pend[$];
    mem_t        mem[$];
    int          drop = 0;
    logic [31:0] m_pc = RPC;
    int          cyc = 0;
    bit          known = 0;
    int          n_cmp = 0, n_err = 0;
    int          p_ready, p_oready, p_redir, p_rsp, p_rst, min_lat, max_lat;
    bit          force_rst, force_redir;
    logic [31:0] redir_target;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask
    task automatic step();
        bit          rsp_hit, ev_req, ev_out;
        ent_t        e;
        mem_t        m;
        @(negedge clk);
        reset = !(force_rst || $urandom_range(999) < p_rst);
        bus.redirect_valid = reset && (force_redir || $urandom_range(99) < p_redir);
        bus.redirect_pc = force_redir ? redir_target : ($urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | $urandom_range(15)));
        bus.imem_req_ready = $urandom_range(99) < p_ready;
        bus.out_ready = $urandom_range(99) < p_oready;
        rsp_hit = mem.size() != 0 && mem[0].due <= cyc && $urandom_range(99) < p_rsp;
        bus.imem_rsp_valid = rsp_hit || (mem.size() == 0 && reset && !bus.redirect_valid && $urandom_range(99) < 3);
        bus.imem_rsp_instr = rsp_hit ? mem[0].instr : $urandom;
        #1;
        ev_req = reset && !bus.redirect_valid && (fq.size() + pend.size() + drop < D);
        ev_out = reset && !bus.redirect_valid && fq.size() != 0;
        if (known) begin
            check("req_valid", 64'(bus.imem_req_valid), 64'(ev_req));
            check("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
            check("out_valid", 64'(bus.out_valid), 64'(ev_out));
            check("out_pc", 64'(bus.out_pc), 64'(fq.size() != 0 ? fq[0].pc : 32'h0));
            check("out_instr", 64'(bus.out_instr), 64'(fq.size() != 0 ? fq[0].instr : 32'h0));
            check("fq_count", 64'(bus.fq_count), 64'(fq.size()));
        end
        if (!reset) begin
            fq.delete();
            pend.delete();
            drop = 0;
            m_pc = RPC;
        end else if (bus.redirect_valid) begin
            drop += pend.size();
            if (bus.imem_rsp_valid && drop > 0)
                drop--;
            pend.delete();
            fq.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (ev_out && bus.out_ready)
                void'(fq.pop_front());
            if (bus.imem_rsp_valid) begin
                if (drop > 0)
                    drop--;
                else if (pend.size() != 0) begin
                    e.pc = pend.pop_front();
                    e.instr = bus.imem_rsp_instr;
                    fq.push_back(e);
                end
            end
            if (ev_req && bus.imem_req_ready) begin
                pend.push_back(m_pc);
                m_pc += 32'd4;
            end
        end
        if (rsp_hit)
            void'(mem.pop_front());
        if (ev_req && bus.imem_req_ready) begin
            m.due = cyc + int'($urandom_range(max_lat, min_lat));
            m.instr = $urandom;
            mem.push_back(m);
        end
        if (!reset)
            mem.delete();
        known = 1;
        cyc++;
    endtask
    initial begin
        bus.redirect_valid = 0;
        bus.redirect_pc = '0;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_instr = '0;
        bus.out_ready = 0;
        p_ready = 100; p_oready = 100; p_redir = 0; p_rsp = 100; p_rst = 0;
        min_lat = 1; max_lat = 1; force_redir = 0; redir_target = '0;
        force_rst = 1;
        repeat (3) step();
        force_rst = 0;
        step();
        check("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("first_req_addr", 64'(bus.imem_req_addr), 64'(RPC));
        repeat (20) step();
        p_oready = 0;
        repeat (10) step();
        check("bp_fq_count", 64'(bus.fq_count), 64'd4);
        check("bp_req_valid", 64'(bus.imem_req_valid), 64'd0);
        p_oready = 100;
        step();
        p_oready = 0;
        repeat (5) step();
        p_oready = 100;
        min_lat = 3; max_lat = 3;
        repeat (8) step();
        force_redir = 1; redir_target = 32'h0000_0103;
        step();
        force_redir = 0;
        repeat (20) step();
        min_lat = 1; max_lat = 1;
        repeat (6) step();
        force_redir = 1; redir_target = 32'h0000_2000;
        step();
        check("redir_out_valid", 64'(bus.out_valid), 64'd0);
        check("redir_req_valid", 64'(bus.imem_req_valid), 64'd0);
        force_redir = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p_ready = $urandom_range(100, 30);
                p_oready = $urandom_range(100, 20);
                p_rsp = $urandom_range(100, 40);
                p_redir = $urandom_range(10);
                p_rst = $urandom_range(5);
                min_lat = $urandom_range(2, 1);
                max_lat = min_lat + int'($urandom_range(3));
            end
            step();
        end
        p_redir = 0; p_rst = 0; p_oready = 0; p_ready = 100; p_rsp = 100;
        min_lat = 2; max_lat = 2;
        repeat (6) step();
        force_rst = 1;
        step();
        force_rst = 0;
        step();
        check("rst_fq_count", 64'(bus.fq_count), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_req_addr", 64'(bus.imem_req_addr), 64'(RPC));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
